fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  fetch request this cycle.
REQ-005 imem_addr  output  32  word-aligned fetch address, valid when imem_req=1.
REQ-006 imem_rdata  input  32  instruction word, valid exactly one cycle after an accepted imem_req.
REQ-007 redirect_valid  input  1  branch/jump taken from execute; flush and refetch.
REQ-008 redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0).
REQ-009 id_ready  input  1  decode accepts the presented instruction this cycle.
REQ-010 id_valid  output  1  id_pc/id_instr/id_pc_plus4 hold a valid instruction.
REQ-011 id_pc  output  32  PC of presented instruction.
REQ-012 id_instr  output  32  presented instruction word.
REQ-013 id_pc_plus4  output  32  id_pc + 4, modulo 2^32.

Function
REQ-014 State: fetch PC register pc_f; inflight flag (1 outstanding imem request max); 2-entry FIFO of {pc, instr} feeding decode, oldest entry drives id_* outputs.
REQ-015 Every imem request is accepted in the cycle imem_req=1; no grant handshake.
REQ-016 imem_req = 1 iff rst_n=1, redirect_valid=0, and (fifo_count + inflight - (id_valid & id_ready)) < 2.
REQ-017 imem_addr = pc_f always; on request edge pc_f <= pc_f + 4 (wraps 32'hFFFF_FFFC -> 0), inflight <= 1; else inflight <= 0.
REQ-018 Edge after a request: {pc of request, imem_rdata} pushed into FIFO unless squashed (REQ-021).
REQ-019 Pop on edge where id_valid & id_ready; push and pop on the same edge both take effect, count unchanged.
REQ-020 Latency: request accepted at edge k -> id_valid=1 with that instruction after edge k+1 (FIFO empty case); with id_ready held 1, sustained throughput one instruction per cycle.
REQ-021 Redirect (redirect_valid=1 at edge): FIFO cleared, in-flight response discarded, pc_f <= {redirect_pc[31:2],2'b00}; presented instruction is dropped whether or not id_ready=1 (decode treats it as flushed).
REQ-022 Redirect timing: redirect at edge N -> imem_req=1 with imem_addr=redirect target in cycle after N -> first redirected id_valid after edge N+2.
REQ-023 Back-to-back redirects: latest target wins; no fetch between them.
REQ-024 FIFO never overflows: push with count=2 is unreachable by REQ-016; pop with count=0 ignored.
REQ-025 id_valid = (fifo_count != 0); id_* outputs stable while id_valid=1 and id_ready=0.

Reset
REQ-026 While rst_n=0: pc_f=RESET_PC, inflight=0, FIFO empty, imem_req=0, id_valid=0, id_pc=0, id_instr=0, id_pc_plus4=0 (held when FIFO empty).
REQ-027 Reset asserted mid-operation clears all state immediately, discards in-flight response; restart per REQ-028.
REQ-028 First cycle after release: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-029 Reset release, id_ready=1, imem returns 32'h00A00093 @0x0, 32'h00F00113 @0x4 -> id_valid after 2nd edge, id_pc=0x0 id_instr=32'h00A00093 id_pc_plus4=0x4, next cycle id_pc=0x4.
REQ-030 Stream 8 instructions id_ready=1 -> one per cycle, id_pc 0x0..0x1C contiguous, imem_req never 0 after start.
REQ-031 id_ready=0 for 5 cycles mid-stream -> imem_req drops within 2 cycles, FIFO holds 2, id_* stable, resume with no lost or duplicated PC.
REQ-032 redirect_valid=1, redirect_pc=0x40 while id_valid=1 and inflight=1 -> both dropped, next imem_addr=0x40, id_pc=0x40 two edges later, no stale PC presented.
REQ-033 redirect_pc=0x43 -> fetch at 0x40; pc_f=0xFFFFFFFC fetch -> next imem_addr=0x0.
REQ-034 rst_n pulsed low mid-stream with FIFO full -> id_valid=0 immediately, restart at RESET_PC per REQ-028.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end. Keeps a fetch PC, issues at most one
// outstanding instruction-memory request, and buffers returned words in a
// 2-entry FIFO whose oldest entry is presented to decode.
//
// Ports
//   clk             in   clock, all state on rising edge
//   rst_n           in   asynchronous active-low reset
//   imem_req        out  fetch request this cycle (always accepted)
//   imem_addr       out  word-aligned fetch address (= fetch PC)
//   imem_rdata      in   instruction word, one cycle after the request
//   redirect_valid  in   taken branch/jump: flush and refetch
//   redirect_pc     in   new fetch target, bits [1:0] ignored
//   id_ready        in   decode accepts presented instruction
//   id_valid        out  id_* outputs hold a valid instruction
//   id_pc           out  PC of presented instruction
//   id_instr        out  presented instruction word
//   id_pc_plus4     out  id_pc + 4 (mod 2^32)
//
// Handshakes: the decode side is valid/ready -- an instruction transfers on a
// rising edge where id_valid=1 and id_ready=1; id_* stay stable while
// id_valid=1 and id_ready=0. The memory side has no ready: every cycle with
// imem_req=1 is an accepted request and its data arrives on imem_rdata in the
// following cycle. A redirect overrides both sides on the edge it is seen.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
);

  logic [31:0] pc_f_q, pc_f_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  // Entry 0 is always the oldest (head); entry 1 is only used when count=2.
  logic [31:0] e0_pc_q, e0_pc_d, e0_instr_q, e0_instr_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_instr_q, e1_instr_d;

  logic        pop, push, req_int;
  logic [2:0]  occ;

  always_comb begin
    pop  = (count_q != 2'd0) && id_ready;
    // Slots committed after this edge: buffered + in flight - leaving now.
    // pop implies count_q >= 1, so this never underflows.
    occ  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Flop-path request; rst_n is applied only on the output so the reset
    // net stays purely asynchronous.
    req_int = !redirect_valid && (occ < 3'd2);
    push    = inflight_q && !redirect_valid;

    pc_f_d        = pc_f_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    e0_pc_d       = e0_pc_q;
    e0_instr_d    = e0_instr_q;
    e1_pc_d       = e1_pc_q;
    e1_instr_d    = e1_instr_q;

    if (redirect_valid) begin
      // Flush: buffered and in-flight instructions are dropped, including
      // the one currently presented even if decode is taking it.
      pc_f_d  = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
    end else begin
      if (req_int) begin
        pc_f_d        = pc_f_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_f_q;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_pc_d    = inflight_pc_q;
            e0_instr_d = imem_rdata;
          end else begin
            e1_pc_d    = inflight_pc_q;
            e1_instr_d = imem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_pc_d    = e1_pc_q;
          e0_instr_d = e1_instr_q;
          count_d    = count_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; new entry lands behind whatever remains.
          if (count_q == 2'd1) begin
            e0_pc_d    = inflight_pc_q;
            e0_instr_d = imem_rdata;
          end else begin
            e0_pc_d    = e1_pc_q;
            e0_instr_d = e1_instr_q;
            e1_pc_d    = inflight_pc_q;
            e1_instr_d = imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q        <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= 2'd0;
      e0_pc_q       <= 32'h0;
      e0_instr_q    <= 32'h0;
      e1_pc_q       <= 32'h0;
      e1_instr_q    <= 32'h0;
    end else begin
      pc_f_q        <= pc_f_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      e0_pc_q       <= e0_pc_d;
      e0_instr_q    <= e0_instr_d;
      e1_pc_q       <= e1_pc_d;
      e1_instr_q    <= e1_instr_d;
    end
  end

  always_comb begin
    imem_req    = rst_n && req_int;
    imem_addr   = pc_f_q;
    id_valid    = (count_q != 2'd0);
    // Outputs read as zero whenever nothing is presented.
    id_pc       = id_valid ? e0_pc_q : 32'h0;
    id_instr    = id_valid ? e0_instr_q : 32'h0;
    id_pc_plus4 = id_valid ? (e0_pc_q + 32'd4) : 32'h0;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage: directed bench for fetch_stage with a one-cycle-latency
// instruction memory responder.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_pc_plus4    (id_pc_plus4)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words at 0x0/0x4, a tagged
  // pattern elsewhere so every address returns a distinct word.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0)      return 32'h00A0_0093;
    else if (a == 32'h4) return 32'h00F0_0113;
    else                 return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk)
    imem_rdata <= imem_req ? mem(imem_addr) : 32'h0;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rdata     = 32'h0;
    repeat (3) step();

    // reset state
    chk("rst_req",    {31'b0, imem_req}, 32'h0);
    chk("rst_valid",  {31'b0, id_valid}, 32'h0);
    chk("rst_pc",     id_pc,       32'h0);
    chk("rst_instr",  id_instr,    32'h0);
    chk("rst_plus4",  id_pc_plus4, 32'h0);

    // release: first cycle fetches RESET_PC
    rst_n = 1'b1; id_ready = 1'b1; #1;
    chk("rel_req",  {31'b0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);
    step();
    chk("e1_valid", {31'b0, id_valid}, 32'h0);
    chk("e1_addr",  imem_addr, 32'h4);
    step();
    chk("e2_valid", {31'b0, id_valid}, 32'h1);
    chk("e2_pc",    id_pc,       32'h0);
    chk("e2_instr", id_instr,    32'h00A0_0093);
    chk("e2_plus4", id_pc_plus4, 32'h4);
    step();
    chk("e3_pc",    id_pc,    32'h4);
    chk("e3_instr", id_instr, 32'h00F0_0113);

    // sustained stream, one per cycle, up to 0x1C
    for (int i = 2; i < 8; i++) begin
      step();
      chk("stream_pc",    id_pc, 32'(4 * i));
      chk("stream_req",   {31'b0, imem_req}, 32'h1);
      chk("stream_valid", {31'b0, id_valid}, 32'h1);
    end
    chk("stream_instr", id_instr, 32'h5A5A_001C);

    // decode stall for 5 cycles
    id_ready = 1'b0; #1;
    chk("stall_req_drop", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_pc",    id_pc,    32'h1C);
      chk("stall_instr", id_instr, 32'h5A5A_001C);
      chk("stall_req",   {31'b0, imem_req}, 32'h0);
    end
    id_ready = 1'b1; #1;
    chk("resume_pc",   id_pc,     32'h1C);
    chk("resume_req",  {31'b0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h24);
    step(); chk("resume_pc1", id_pc, 32'h20);
    step(); chk("resume_pc2", id_pc, 32'h24);
    step(); chk("resume_pc3", id_pc, 32'h28);

    // redirect with valid instruction presented and a request in flight;
    // unaligned target 0x43 fetches at 0x40
    redirect_valid = 1'b1; redirect_pc = 32'h43; #1;
    chk("redir_req",   {31'b0, imem_req}, 32'h0);
    chk("redir_pre_v", {31'b0, id_valid}, 32'h1);
    step();
    redirect_valid = 1'b0; #1;
    chk("redir_valid0", {31'b0, id_valid}, 32'h0);
    chk("redir_req1",   {31'b0, imem_req}, 32'h1);
    chk("redir_addr",   imem_addr, 32'h40);
    step();
    chk("redir_valid1", {31'b0, id_valid}, 32'h0);
    chk("redir_addr1",  imem_addr, 32'h44);
    step();
    chk("redir_valid2", {31'b0, id_valid}, 32'h1);
    chk("redir_pc",     id_pc,    32'h40);
    chk("redir_instr",  id_instr, 32'h5A5A_0040);

    // back-to-back redirects: latest wins, no fetch between
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("b2b_req0", {31'b0, imem_req}, 32'h0);
    step();
    redirect_pc = 32'h200; #1;
    chk("b2b_req1",   {31'b0, imem_req}, 32'h0);
    chk("b2b_valid1", {31'b0, id_valid}, 32'h0);
    step();
    redirect_valid = 1'b0; #1;
    chk("b2b_addr",  imem_addr, 32'h200);
    chk("b2b_valid", {31'b0, id_valid}, 32'h0);
    step(); step();
    chk("b2b_pc",    id_pc,    32'h200);
    chk("b2b_instr", id_instr, 32'h5A5A_0200);

    // wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    step();
    redirect_valid = 1'b0; #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", imem_addr, 32'h0);
    step();
    chk("wrap_pc",    id_pc,       32'hFFFF_FFFC);
    chk("wrap_plus4", id_pc_plus4, 32'h0);
    chk("wrap_instr", id_instr,    32'hA5A5_FFFC);
    step();
    chk("wrap_pc2",    id_pc,       32'h0);
    chk("wrap_instr2", id_instr,    32'h00A0_0093);
    chk("wrap_plus42", id_pc_plus4, 32'h4);

    // fill FIFO, then reset mid-stream
    id_ready = 1'b0; #1;
    repeat (3) step();
    chk("full_valid", {31'b0, id_valid}, 32'h1);
    chk("full_req",   {31'b0, imem_req}, 32'h0);
    chk("full_instr", id_instr, 32'h00A0_0093);
    rst_n = 1'b0; #1;
    chk("mrst_valid", {31'b0, id_valid}, 32'h0);
    chk("mrst_instr", id_instr, 32'h0);
    chk("mrst_req",   {31'b0, imem_req}, 32'h0);
    step();
    rst_n = 1'b1; id_ready = 1'b1; #1;
    chk("mrel_req",  {31'b0, imem_req}, 32'h1);
    chk("mrel_addr", imem_addr, 32'h0);
    step();
    chk("mrel_valid1", {31'b0, id_valid}, 32'h0);
    step();
    chk("mrel_pc",    id_pc,    32'h0);
    chk("mrel_instr", id_instr, 32'h00A0_0093);
    step();
    chk("mrel_pc2",   id_pc,    32'h4);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
